// File: rtl/posit_job_host.sv
// rtl/posit_job_host.sv - fabric initiator for the posit accelerator shared-memory job protocol
module posit_job_host #(
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'h000,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = 12'h010,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [31:0]           io_num1,
  input  logic [31:0]           io_num2,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [31:0]           io_result,
  output logic                  io_error,
  output logic                  io_busy,
  output logic [ADDR_WIDTH-1:0] io_mem_address,
  output logic                  io_mem_write,
  output logic [7:0]            io_mem_writedata,
  input  logic [7:0]            io_mem_readdata,
  output logic                  io_start,
  input  logic                  io_completed
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);
  localparam logic [2:0] RD_LAST = 3'(3 + READ_LATENCY);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_CLR,
    S_RUN,
    S_READ,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             num1_q, num2_q, result_q;
  logic                    error_q;
  logic [2:0]              beat_q;
  logic [2:0]              rd_q;
  logic [CW-1:0]           run_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [63:0]             ops;
  logic [1:0]              cap_idx;
  logic                    run_timeout;

  logic                    in_ready_c, out_valid_c, write_c, start_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [7:0]              wdata_c;

  assign ops         = {num2_q, num1_q};
  assign cap_idx     = 2'(rd_q - RD_LAT);
  assign run_timeout = (run_q == RUN_LAST);

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    out_valid_c = 1'b0;
    write_c    = 1'b0;
    start_c    = 1'b0;
    addr_c     = addr_q;
    wdata_c    = 8'h00;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (io_in_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        write_c = 1'b1;
        addr_c  = START_ADDR + ADDR_WIDTH'(beat_q);
        wdata_c = ops[{beat_q, 3'b000} +: 8];
        if (beat_q == 3'd7) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // a completion left high by the previous job must not start this one
        if (!io_completed) state_d = S_RUN;
      end
      S_RUN: begin
        start_c = 1'b1;
        if (io_completed) state_d = S_READ;
        else if (run_timeout) state_d = S_RESP;
      end
      S_READ: begin
        if (rd_q < 3'd4) addr_c = RESULT_ADDR + ADDR_WIDTH'(rd_q);
        if (rd_q == RD_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        out_valid_c = 1'b1;
        if (io_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      num1_q   <= '0;
      num2_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      beat_q   <= '0;
      rd_q     <= '0;
      run_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_c;
      case (state_q)
        S_IDLE: begin
          if (io_in_valid) begin
            num1_q   <= io_num1;
            num2_q   <= io_num2;
            result_q <= '0;
            error_q  <= 1'b0;
            beat_q   <= '0;
            rd_q     <= '0;
            run_q    <= '0;
          end
        end
        S_WRITE: beat_q <= beat_q + 3'd1;
        S_WAIT_CLR: run_q <= '0;
        S_RUN: begin
          if (io_completed) begin
            run_q <= '0;
            rd_q  <= '0;
          end else if (run_timeout) begin
            run_q    <= '0;
            error_q  <= 1'b1;
            result_q <= '0;
          end else begin
            run_q <= run_q + 1'b1;
          end
        end
        S_READ: begin
          rd_q <= rd_q + 3'd1;
          if (rd_q >= RD_LAT) result_q[{cap_idx, 3'b000} +: 8] <= io_mem_readdata;
        end
        default: ;
      endcase
    end
  end

  // every output is forced low while reset is held, even before the state register clears
  assign io_in_ready      = in_ready_c & ~reset;
  assign io_out_valid     = out_valid_c & ~reset;
  assign io_mem_write     = write_c & ~reset;
  assign io_start         = start_c & ~reset;
  assign io_busy          = (state_q != S_IDLE) & ~reset;
  assign io_error         = error_q & ~reset;
  assign io_result        = reset ? 32'h0 : result_q;
  assign io_mem_address   = reset ? '0 : addr_c;
  assign io_mem_writedata = reset ? 8'h00 : wdata_c;

endmodule

// File: tb/tb_posit_job_host.sv
// tb/tb_posit_job_host.sv - bench for posit_job_host across read latencies 1..3
module tb_posit_job_host;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI];
  logic        in_valid [NI], in_ready [NI], out_valid [NI], out_ready [NI];
  logic        err [NI], busy [NI], mwrite [NI], start [NI], completed [NI];
  logic [31:0] num1 [NI], num2 [NI], result [NI];
  logic [11:0] maddr [NI];
  logic [7:0]  wdata [NI], rdata [NI];
  logic [31:0] stub_res [NI];
  int          stub_dly [NI];
  logic        stale [NI];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? 16 : 4096;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    logic [7:0] mem [4096];
    logic [7:0] pipe [3];
    int         sc = 0;
    logic       comp = 1'b0;

    posit_job_host #(
      .ADDR_WIDTH(12), .START_ADDR(12'h000), .RESULT_ADDR(12'h010),
      .READ_LATENCY(g + 1), .TIMEOUT_CYCLES((g == 0) ? 16 : 4096)
    ) dut (
      .clock(clk), .reset(rst[g]),
      .io_in_valid(in_valid[g]), .io_in_ready(in_ready[g]),
      .io_num1(num1[g]), .io_num2(num2[g]),
      .io_out_valid(out_valid[g]), .io_out_ready(out_ready[g]),
      .io_result(result[g]), .io_error(err[g]), .io_busy(busy[g]),
      .io_mem_address(maddr[g]), .io_mem_write(mwrite[g]),
      .io_mem_writedata(wdata[g]), .io_mem_readdata(rdata[g]),
      .io_start(start[g]), .io_completed(completed[g])
    );

    assign completed[g] = comp | stale[g];
    assign rdata[g]     = pipe[g];

    // memory with a read pipeline plus an accelerator stub that posts its result then completes
    always @(posedge clk) begin
      pipe[0] <= mem[maddr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (mwrite[g]) mem[maddr[g]] <= wdata[g];
      if (start[g]) begin
        sc <= sc + 1;
        if (sc + 1 == stub_dly[g]) begin
          comp     <= 1'b1;
          mem[16]  <= stub_res[g][7:0];
          mem[17]  <= stub_res[g][15:8];
          mem[18]  <= stub_res[g][23:16];
          mem[19]  <= stub_res[g][31:24];
        end
      end else begin
        sc   <= 0;
        comp <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input int k, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (in_ready[k] !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    check("in_ready_before_submit", in_ready[k], 1'b1);
    num1[k] = a;
    num2[k] = b;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
  endtask

  // called one cycle after the accepting edge; returns at the first out_valid cycle
  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_err,
                         input int dly, input int stale_n, input string tag);
    logic [19:0] wq [$];
    int n, first_start, last_start, extra, exp_n;
    logic rd_seen, ir_seen;
    first_start = -1;
    last_start = -1;
    rd_seen = 1'b0;
    ir_seen = 1'b0;
    for (n = 1; n < 300; n++) begin
      if (stale_n == n) stale[k] = 1'b0;
      if (out_valid[k] === 1'b1) break;
      if (mwrite[k] === 1'b1) wq.push_back({maddr[k], wdata[k]});
      else if (maddr[k] >= 12'h010 && maddr[k] <= 12'h013) rd_seen = 1'b1;
      if (start[k] === 1'b1) begin
        if (first_start < 0) first_start = n;
        last_start = n;
      end
      if (in_ready[k] !== 1'b0) ir_seen = 1'b1;
      tick();
    end
    extra = (stale_n > 0) ? stale_n - 9 : 0;
    exp_n = 10 + extra + (exp_err ? to_of(k) : (dly + 1 + 4 + lat_of(k)));
    check({tag, "_out_valid"}, out_valid[k], 1'b1);
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_write_count"}, wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      logic [19:0] o;
      w = (i < 4) ? a : b;
      o = (i < wq.size()) ? wq[i] : 20'hfffff;
      check({tag, "_write_beat"}, o, {12'(i), 8'(w >> (8 * (i % 4)))});
    end
    check({tag, "_first_start"}, first_start, 10 + extra);
    if (exp_err) begin
      check({tag, "_run_cycles"}, last_start - first_start + 1, to_of(k));
      check({tag, "_no_reads"}, rd_seen, 1'b0);
    end else begin
      check({tag, "_read_cycles"}, n - last_start - 1, 4 + lat_of(k));
    end
    check({tag, "_result"}, result[k], exp_res);
    check({tag, "_error"}, err[k], exp_err);
    check({tag, "_start_low"}, start[k], 1'b0);
    check({tag, "_busy"}, busy[k], 1'b1);
    check({tag, "_in_ready_low"}, ir_seen, 1'b0);
  endtask

  task automatic drain(input int k, input int bp, input logic [31:0] exp_res, input logic exp_err);
    logic held = 1'b1;
    out_ready[k] = 1'b0;
    for (int i = 0; i < bp; i++) begin
      if (out_valid[k] !== 1'b1 || result[k] !== exp_res || err[k] !== exp_err) held = 1'b0;
      tick();
    end
    check("resp_held", held, 1'b1);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check("idle_in_ready", in_ready[k], 1'b1);
    check("idle_out_valid", out_valid[k], 1'b0);
    check("idle_busy", busy[k], 1'b0);
  endtask

  task automatic job(input int k, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int dly, input int bp, input string tag);
    logic e;
    e = (dly + 1 > to_of(k));
    stub_res[k] = res;
    stub_dly[k] = dly;
    submit(k, a, b);
    observe(k, a, b, e ? 32'h0 : res, e, dly, 0, tag);
    drain(k, bp, e ? 32'h0 : res, e);
  endtask

  task automatic reset_mid(input int k, input int at_n, input logic exp_write, input logic exp_start);
    logic ov_seen = 1'b0;
    stub_dly[k] = 1000;
    submit(k, $urandom, $urandom);
    for (int n = 1; n < at_n; n++) tick();
    check("pre_reset_write", mwrite[k], exp_write);
    check("pre_reset_start", start[k], exp_start);
    rst[k] = 1'b1;
    #1;
    check("in_reset_outputs", {mwrite[k], start[k], in_ready[k], busy[k]}, 4'b0000);
    tick();
    rst[k] = 1'b0;
    #1;
    check("post_reset_write", mwrite[k], 1'b0);
    check("post_reset_start", start[k], 1'b0);
    check("post_reset_idle", in_ready[k], 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (out_valid[k] !== 1'b0) ov_seen = 1'b1;
      tick();
    end
    check("no_out_after_reset", ov_seen, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      num1[k] = '0;
      num2[k] = '0;
      stub_res[k] = '0;
      stub_dly[k] = 1000;
      stale[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      check("reset_outputs",
            {in_ready[k], out_valid[k], mwrite[k], start[k], busy[k], err[k], maddr[k], result[k]},
            '0);
      rst[k] = 1'b0;
    end
    tick();
    for (int k = 0; k < NI; k++) check("reset_release_ready", in_ready[k], 1'b1);

    job(0, 32'h40000000, 32'h40000000, 32'h48000000, 10, 0, "basic");

    stub_res[0] = 32'h12345678;
    stub_dly[0] = 5;
    stale[0] = 1'b1;
    submit(0, 32'h11223344, 32'h55667788);
    observe(0, 32'h11223344, 32'h55667788, 32'h12345678, 1'b0, 5, 14, "stale");
    drain(0, 0, 32'h12345678, 1'b0);

    job(0, 32'hdeadbeef, 32'h01020304, 32'hcafef00d, 1000, 2, "timeout");
    job(0, 32'h0badf00d, 32'h13572468, 32'h76543210, 15, 0, "tie_completes");
    job(0, 32'h0f0f0f0f, 32'hf0f0f0f0, 32'h99999999, 16, 0, "just_times_out");

    stub_res[1] = 32'h3c000000;
    stub_dly[1] = 7;
    submit(1, 32'h3f800000, 32'h40400000);
    num1[1] = 32'h38000000;
    num2[1] = 32'h40000000;
    in_valid[1] = 1'b1;
    observe(1, 32'h3f800000, 32'h40400000, 32'h3c000000, 1'b0, 7, 0, "bp_job1");
    drain(1, 20, 32'h3c000000, 1'b0);
    stub_res[1] = 32'h44000000;
    stub_dly[1] = 4;
    submit(1, 32'h38000000, 32'h40000000);
    observe(1, 32'h38000000, 32'h40000000, 32'h44000000, 1'b0, 4, 0, "b2b_job2");
    drain(1, 0, 32'h44000000, 1'b0);

    job(1, 32'h12121212, 32'h34343434, 32'ha1b2c3d4, 3, 0, "lat2");
    job(2, 32'h56565656, 32'h78787878, 32'ha1b2c3d4, 3, 0, "lat3");

    reset_mid(0, 4, 1'b1, 1'b0);
    reset_mid(0, 12, 1'b0, 1'b1);
    job(0, 32'h40000000, 32'h38000000, 32'h41000000, 6, 1, "after_reset");

    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 4; j++) begin
        job(k, $urandom, $urandom, $urandom, $urandom_range(1, 20), $urandom_range(0, 3), "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
